// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: registers address/store data, runs one RAM cycle with byte enables,
// waits for MOC (with timeout) and returns sign/zero-extended load data with a one-cycle ack.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic        ram_en,
  output logic        ram_rw,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_moc
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, stateNext;
  logic [31:0] mar, mdr, rdataReg, loadExt;
  logic [3:0]  beReg, laneBe;
  logic [31:0] laneData;
  logic [1:0]  sizeReg;
  logic        weReg, unsignReg, errFlag;
  logic [7:0]  cnt;
  logic        reqIllegal, timeoutHit;
  logic [7:0]  ldByte;
  logic [15:0] ldHalf;

  assign reqIllegal = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                      (size == 2'b10 && addr[1:0] != 2'b00);
  assign timeoutHit = (state == ACCESS) && !ram_moc && (cnt == CNT_LAST);

  // Store lane steering: narrow data is replicated, enables pick the big-endian lane(s)
  always_comb begin
    laneBe   = 4'b1111;
    laneData = wdata;
    case (size)
      2'b00: begin
        laneBe   = 4'b1000 >> addr[1:0];
        laneData = {4{wdata[7:0]}};
      end
      2'b01: begin
        laneBe   = addr[1] ? 4'b0011 : 4'b1100;
        laneData = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ldByte = ram_rdata[31:24];
    case (mar[1:0])
      2'd1:    ldByte = ram_rdata[23:16];
      2'd2:    ldByte = ram_rdata[15:8];
      2'd3:    ldByte = ram_rdata[7:0];
      default: ;
    endcase
    ldHalf  = mar[1] ? ram_rdata[15:0] : ram_rdata[31:16];
    loadExt = ram_rdata;
    case (sizeReg)
      2'b00:   loadExt = {{24{!unsignReg & ldByte[7]}}, ldByte};
      2'b01:   loadExt = {{16{!unsignReg & ldHalf[15]}}, ldHalf};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    ack       = 1'b0;
    ram_en    = 1'b0;
    ram_rw    = 1'b0;
    case (state)
      IDLE: if (req) stateNext = reqIllegal ? RESP : ACCESS;
      ACCESS: begin
        busy   = 1'b1;
        ram_en = 1'b1;
        ram_rw = weReg;
        if (ram_moc || timeoutHit) stateNext = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        ack       = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mar       <= '0;
      mdr       <= '0;
      beReg     <= '0;
      sizeReg   <= '0;
      weReg     <= 1'b0;
      unsignReg <= 1'b0;
      errFlag   <= 1'b0;
      cnt       <= '0;
      rdataReg  <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          if (reqIllegal) begin
            errFlag <= 1'b1;
          end else begin
            mar       <= addr;
            mdr       <= laneData;
            beReg     <= laneBe;
            sizeReg   <= size;
            weReg     <= we;
            unsignReg <= unsign;
            errFlag   <= 1'b0;
            cnt       <= '0;
          end
        end
        ACCESS: begin
          if (ram_moc) begin
            if (!weReg) rdataReg <= loadExt;
          end else if (timeoutHit) begin
            errFlag <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign err       = ack & errFlag;
  assign rdata     = rdataReg;
  assign ram_addr  = {mar[31:2], 2'b00};
  assign ram_be    = beReg;
  assign ram_wdata = mdr;

endmodule
